line_deserializer: RTL and testbench

//  Multi-lane serial-to-parallel line readout stage. Collects LANES bits per

---
 rtl/fro_pkg.sv | 26 ++
 rtl/line_shift_core.sv | 79 +++++++
 rtl/line_deserializer.sv | 117 +++++++++++
 tb/tb_line_deserializer.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fro_pkg.sv
// Shared types and constants for the line_deserializer readout slice.
// FRO_LINE_PARITY_EN selects the per-lane trailing parity cycle.
package fro_pkg;

  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_t;

`ifdef FRO_LINE_PARITY_EN
  localparam int FRO_PARITY_BITS = 1;
`else
  localparam int FRO_PARITY_BITS = 0;
`endif

  // Ceiling log2, never below 1 so derived vectors always have a bit.
  function automatic int fro_clog2(input int value);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/line_shift_core.sv
// Shift register, bit counter and completion pulse for one image line.
// With FRO_LINE_PARITY_EN a trailing parity cycle is checked per lane.
module line_shift_core
  import fro_pkg::*;
#(
  parameter int W     = 32,
  parameter int LANES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [LANES-1:0] sdata_in,
  input  logic             sdata_valid,
  input  logic             sync_clr,
  output logic [W-1:0]     line_next,
  output logic             line_done,
  output logic             busy,
  output logic             parity_bad
);

  localparam int LB   = W / LANES;
  localparam int LAST = LB - 1 + FRO_PARITY_BITS;
  localparam int CW   = fro_clog2(LB + 1);

  logic [W-1:0]  shreg_q, shreg_d, shifted;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          take, data_phase;

  always_comb begin
    shifted    = {shreg_q[W-LANES-1:0], sdata_in};
    take       = sdata_valid && !sync_clr;
    data_phase = (cnt_q < CW'(LB));
    line_done  = take && (cnt_q == CW'(LAST));
    shreg_d    = shreg_q;
    cnt_d      = cnt_q;
    if (sync_clr) begin
      shreg_d = '0;
      cnt_d   = '0;
    end else if (sdata_valid) begin
      if (data_phase) shreg_d = shifted;
      cnt_d = line_done ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy = (cnt_q != '0);

`ifdef FRO_LINE_PARITY_EN
  logic [LANES-1:0] par_q, par_d;

  // The line is already complete in shreg when the parity cycle arrives.
  always_comb begin
    par_d = par_q;
    if (sync_clr || line_done) par_d = '0;
    else if (sdata_valid && data_phase) par_d = par_q ^ sdata_in;
    line_next  = shreg_q;
    parity_bad = |(par_q ^ sdata_in);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) par_q <= '0;
    else          par_q <= par_d;
  end
`else
  always_comb begin
    line_next  = shifted;
    parity_bad = 1'b0;
  end
`endif

endmodule

// File: rtl/line_deserializer.sv
// Multi-lane serial-to-parallel line readout with held output register,
// frame line index and drop flag. FRO_LINE_PARITY_EN enables parity_err.
module line_deserializer
  import fro_pkg::*;
#(
  parameter int PIX_BITS        = 8,
  parameter int LINE_PIXELS     = 1024,
  parameter int LANES           = 1,
  parameter int LINES_PER_FRAME = 1024,
  localparam int W  = LINE_PIXELS * PIX_BITS,
  localparam int IW = fro_clog2(LINES_PER_FRAME)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [LANES-1:0] sdata_in,
  input  logic             sdata_valid,
  input  logic             sync_clr,
  output logic [W-1:0]     line_data,
  output logic             line_valid,
  input  logic             line_ready,
  output logic [IW-1:0]    line_idx,
  output logic             frame_last,
  output logic             busy,
  output logic             overflow,
  input  logic             ovf_clr,
  output logic             parity_err,
  output out_state_t       dbg_state
);

  generate
    if (W % LANES != 0) begin : g_lane_check
      $error("line_deserializer: line width must be a multiple of LANES");
    end
  endgenerate

  logic [W-1:0] line_next;
  logic         line_done, parity_bad;

  line_shift_core #(
    .W     (W),
    .LANES (LANES)
  ) u_core (
    .clk         (clk),
    .reset_n     (reset_n),
    .sdata_in    (sdata_in),
    .sdata_valid (sdata_valid),
    .sync_clr    (sync_clr),
    .line_next   (line_next),
    .line_done   (line_done),
    .busy        (busy),
    .parity_bad  (parity_bad)
  );

  out_state_t    state_q, state_d;
  logic [W-1:0]  line_data_q, line_data_d;
  logic [IW-1:0] line_idx_q, line_idx_d;
  logic [IW-1:0] frame_q, frame_d;
  logic          overflow_q, overflow_d;
  logic          parity_err_q, parity_err_d;
  logic          accept, drop;

  // Handshake: a line transfers on any cycle with line_valid && line_ready;
  // line_data holds steady while line_valid is high and line_ready is low.
  // A completion in that same cycle refills the register instead of dropping.
  always_comb begin
    accept       = line_done && ((state_q == OUT_EMPTY) || line_ready);
    drop         = line_done && !accept;
    state_d      = state_q;
    line_data_d  = line_data_q;
    line_idx_d   = line_idx_q;
    parity_err_d = parity_err_q;
    if (accept) begin
      state_d      = OUT_FULL;
      line_data_d  = line_next;
      line_idx_d   = frame_q;
      parity_err_d = parity_bad;
    end else if ((state_q == OUT_FULL) && line_ready) begin
      state_d = OUT_EMPTY;
    end

    frame_d = frame_q;
    if (sync_clr) frame_d = '0;
    else if (line_done)
      frame_d = (frame_q == IW'(LINES_PER_FRAME - 1)) ? '0 : frame_q + 1'b1;

    overflow_d = overflow_q;
    if (drop)         overflow_d = 1'b1;
    else if (ovf_clr) overflow_d = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= OUT_EMPTY;
      line_data_q  <= '0;
      line_idx_q   <= '0;
      frame_q      <= '0;
      overflow_q   <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      line_data_q  <= line_data_d;
      line_idx_q   <= line_idx_d;
      frame_q      <= frame_d;
      overflow_q   <= overflow_d;
      parity_err_q <= parity_err_d;
    end
  end

  assign line_data  = line_data_q;
  assign line_valid = (state_q == OUT_FULL);
  assign line_idx   = line_idx_q;
  assign frame_last = line_valid && (line_idx_q == IW'(LINES_PER_FRAME - 1));
  assign overflow   = overflow_q;
  assign parity_err = parity_err_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_line_deserializer.sv
// Self-checking bench for line_deserializer (W=32, two lanes, 3-line frames).
// Line-level reference model plus directed tables and hand sequences.
module tb_line_deserializer;

  localparam int W     = 32;
  localparam int LANES = 2;
  localparam int LB    = 16;
  localparam int LPF   = 3;
`ifdef FRO_LINE_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int LEN = LB + PB;

  logic             clk = 1'b0;
  logic             reset_n;
  logic [LANES-1:0] sdata_in;
  logic             sdata_valid, sync_clr, line_ready, ovf_clr;
  logic [W-1:0]     line_data;
  logic             line_valid, frame_last, busy, overflow, parity_err;
  logic [1:0]       line_idx;
  fro_pkg::out_state_t dbg_state;

  line_deserializer #(
    .PIX_BITS        (8),
    .LINE_PIXELS     (4),
    .LANES           (LANES),
    .LINES_PER_FRAME (LPF)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .sdata_in    (sdata_in),
    .sdata_valid (sdata_valid),
    .sync_clr    (sync_clr),
    .line_data   (line_data),
    .line_valid  (line_valid),
    .line_ready  (line_ready),
    .line_idx    (line_idx),
    .frame_last  (frame_last),
    .busy        (busy),
    .overflow    (overflow),
    .ovf_clr     (ovf_clr),
    .parity_err  (parity_err),
    .dbg_state   (dbg_state)
  );

  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;
  logic [W-1:0] exp_q[$];

  // Reference model: line-level bookkeeping of the readout rules.
  int           m_cnt, m_frame, m_idx;
  bit           m_valid, m_ovf, m_perr;
  logic [W-1:0] m_data;
  logic [W-1:0] cur_line;
  bit           cur_bad;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_frame = 0; m_idx = 0;
    m_valid = 0; m_ovf = 0; m_perr = 0; m_data = '0;
    exp_q.delete();
  endtask

  function automatic logic [1:0] lane_bits(input logic [W-1:0] line, input int k, input bit bad);
    logic [1:0] p;
    p = '0;
    if (k < LB) return line[W-1-2*k -: 2];
    for (int i = 0; i < W; i++) p[i%2] ^= line[i];
    p[0] ^= bad;
    return p;
  endfunction

  task automatic tick(input bit v, input logic [1:0] d, input bit sc, input bit rdy, input bit oc);
    bit dut_del, m_del, done, drop;
    logic [W-1:0] dut_word;
    sdata_valid = v; sdata_in = d; sync_clr = sc; line_ready = rdy; ovf_clr = oc;
    #1;
    dut_del  = line_valid && line_ready;
    dut_word = line_data;
    @(posedge clk);
    done  = v && !sc && (m_cnt == LEN - 1);
    drop  = 0;
    m_del = m_valid && rdy;
    if (m_del) exp_q.push_back(m_data);
    if (sc) begin
      m_cnt = 0; m_frame = 0;
    end else if (v) begin
      m_cnt = done ? 0 : m_cnt + 1;
    end
    if (done) begin
      if (!m_valid || rdy) begin
        m_data = cur_line; m_idx = m_frame; m_perr = (PB != 0) && cur_bad; m_valid = 1;
      end else begin
        drop = 1;
      end
      m_frame = (m_frame + 1) % LPF;
    end else if (m_valid && rdy) begin
      m_valid = 0;
    end
    if (drop)    m_ovf = 1;
    else if (oc) m_ovf = 0;
    #1;
    chk("line_valid", line_valid, m_valid);
    chk("overflow", overflow, m_ovf);
    chk("busy", busy, m_cnt != 0);
    chk("frame_last", frame_last, m_valid && (m_idx == LPF - 1));
    chk("parity_err", parity_err, m_perr);
    chk("dbg_state", dbg_state == fro_pkg::OUT_FULL, m_valid);
    chk("deliver", dut_del, m_del);
    if (m_valid) begin
      chk("line_data", line_data, m_data);
      chk("line_idx", line_idx, m_idx);
    end
    if (dut_del && m_del) chk("delivered_line", dut_word, exp_q.pop_front());
  endtask

  task automatic send_line(input logic [W-1:0] line, input bit bad, input bit rdy_body,
                           input bit rdy_last, input bit oc_last);
    cur_line = line; cur_bad = bad;
    for (int k = 0; k < LEN; k++)
      tick(1'b1, lane_bits(line, k, bad), 1'b0, (k == LEN - 1) ? rdy_last : rdy_body,
           (k == LEN - 1) ? oc_last : 1'b0);
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_valid"}, line_valid, 0);
    chk({tag, "_data"}, line_data, 0);
    chk({tag, "_idx"}, line_idx, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_ovf"}, overflow, 0);
    chk({tag, "_perr"}, parity_err, 0);
    chk({tag, "_flast"}, frame_last, 0);
  endtask

  typedef struct {
    logic [W-1:0] line;
    bit           clr_before;
    bit           ready_last;
    logic [W-1:0] exp_data;
    logic [1:0]   exp_idx;
    bit           exp_ovf;
  } vec_t;

  vec_t vecs[3];

  initial begin
    vecs[0] = '{32'h11111111, 1'b0, 1'b0, 32'hA1B2C3D4, 2'd0, 1'b1};
    vecs[1] = '{32'h22222222, 1'b0, 1'b0, 32'hA1B2C3D4, 2'd0, 1'b1};
    vecs[2] = '{32'h33333333, 1'b1, 1'b1, 32'h33333333, 2'd0, 1'b0};

    reset_n = 1'b0; sdata_in = '0; sdata_valid = 0; sync_clr = 0; line_ready = 0; ovf_clr = 0;
    cur_line = '0; cur_bad = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset_checks("por");
    @(negedge clk) reset_n = 1'b1;

    // Reset in the middle of a line with another line held.
    send_line(32'h5A5A0F0F, 0, 0, 0, 0);
    cur_line = $urandom();
    for (int k = 0; k < 7; k++) tick(1, lane_bits(cur_line, k, 0), 0, 0, 0);
    sdata_valid = 0;
    #2 reset_n = 1'b0;
    #1 reset_checks("mid_rst");
    model_reset();
    @(negedge clk) reset_n = 1'b1;

    // First line after reset, ready high throughout.
    send_line(32'hA1B2C3D4, 0, 1, 1, 0);
    chk("t2_valid", line_valid, 1);
    chk("t2_data", line_data, 32'hA1B2C3D4);
    chk("t2_idx", line_idx, 0);

    // Held line, drops, overflow clear, replace-on-ready.
    for (int i = 0; i < 3; i++) begin
      if (vecs[i].clr_before) begin
        tick(0, 2'b00, 0, 0, 1);
        chk("tbl_ovf_clr", overflow, 0);
      end
      send_line(vecs[i].line, 0, 0, vecs[i].ready_last, 0);
      chk("tbl_valid", line_valid, 1);
      chk("tbl_data", line_data, vecs[i].exp_data);
      chk("tbl_idx", line_idx, vecs[i].exp_idx);
      chk("tbl_ovf", overflow, vecs[i].exp_ovf);
    end

    // Drop and ovf_clr in the same cycle: set wins.
    send_line(32'h44444444, 0, 0, 0, 1);
    chk("set_wins_ovf", overflow, 1);
    chk("set_wins_data", line_data, 32'h33333333);

    // sync_clr with a concurrent sample: sample discarded, frame restarts.
    tick(1, 2'b11, 1, 1, 1);
    chk("sclr_busy", busy, 0);
    for (int i = 0; i < 3; i++) begin
      send_line($urandom(), 0, 1, 1, 0);
      chk("frame_idx", line_idx, i);
      chk("frame_last_seq", frame_last, i == 2);
    end
    cur_line = $urandom();
    for (int k = 0; k < 5; k++) tick(1, lane_bits(cur_line, k, 0), 0, 1, 0);
    chk("partial_busy", busy, 1);
    tick(0, 2'b00, 1, 1, 0);
    chk("sclr_busy_drop", busy, 0);
    send_line(32'hCAFEF00D, 0, 1, 1, 0);
    chk("after_sclr_idx", line_idx, 0);
    chk("after_sclr_data", line_data, 32'hCAFEF00D);

`ifdef FRO_LINE_PARITY_EN
    send_line(32'hA1B2C3D4, 1, 1, 1, 0);
    chk("parity_bad", parity_err, 1);
    send_line(32'hA1B2C3D4, 0, 1, 1, 0);
    chk("parity_good", parity_err, 0);
`endif

    // Randomized traffic against the model.
    for (int n = 0; n < 40; n++) begin
      int  k;
      bit  v, sc, rdy, oc;
      cur_line = $urandom();
      cur_bad  = (PB != 0) && ($urandom_range(0, 3) == 0);
      k = 0;
      while (k < LEN) begin
        v   = ($urandom_range(0, 3) != 0);
        sc  = ($urandom_range(0, 59) == 0);
        rdy = $urandom_range(0, 1);
        oc  = ($urandom_range(0, 9) == 0);
        tick(v, lane_bits(cur_line, k, cur_bad), sc, rdy, oc);
        if (sc)     k = 0;
        else if (v) k++;
      end
    end
    tick(0, 2'b00, 0, 1, 0);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
